// File: rtl/relay_drv.sv
// Relay output driver: qualifies a synchronized level request for QUAL_TICKS ticks,
// switches the relay, then freezes it for HOLD_TICKS ticks. Define RELAY_DRV_CHG_CNT_EN for chg_cnt_o.
module relay_drv #(
    parameter int unsigned PRESCALE   = 65536,
    parameter int unsigned QUAL_TICKS = 4,
    parameter int unsigned HOLD_TICKS = 8,
    parameter logic        INIT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        relay_o,
    output logic        busy_o,
    output logic        chg_o
`ifdef RELAY_DRV_CHG_CNT_EN
    ,
    output logic [15:0] chg_cnt_o
`endif
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned QW = (QUAL_TICKS > 1) ? $clog2(QUAL_TICKS) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);
    localparam logic [QW-1:0] Q_MAX   = QW'(QUAL_TICKS - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [PW-1:0] psc_q;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          relay_d;
    logic          chg_d;
    logic          req_s;
    logic          tick;

    assign req_s = sync_q[1];
    assign tick  = (psc_q == PSC_MAX);

    // Synchronizer and free-running prescaler; the prescaler ignores FSM activity.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{INIT}};
            psc_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], req_i};
            psc_q  <= tick ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            hcnt_q  <= '0;
            relay_o <= INIT;
            chg_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            hcnt_q  <= hcnt_d;
            relay_o <= relay_d;
            chg_o   <= chg_d;
            busy_o  <= (state_d != IDLE);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        hcnt_d  = hcnt_q;
        relay_d = relay_o;
        chg_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s != relay_o) begin
                    state_d = QUAL;
                    qcnt_d  = '0;
                end
            end
            QUAL: begin
                // A request that falls back wins over a coincident final tick.
                if (req_s == relay_o) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (qcnt_q == Q_MAX) begin
                        relay_d = ~relay_o;
                        chg_d   = 1'b1;
                        state_d = HOLD;
                        hcnt_d  = '0;
                    end else begin
                        qcnt_d = qcnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hcnt_q == H_MAX) begin
                        state_d = IDLE;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RELAY_DRV_CHG_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_cnt_o <= '0;
        end else if (chg_d && (chg_cnt_o != 16'hFFFF)) begin
            chg_cnt_o <= chg_cnt_o + 16'd1;
        end
    end
`endif

endmodule
